ysyx_25060170_gpr_mp: RTL and testbench

Parametrised multi-port general-purpose register file with an integrated pending-write scoreboard. It replaces the single-read/single-write GPR in the NPC core and serves N combinational read ports and M write ports. Optional same-cycle write-to-read bypass. Per-register busy bits let the decode stage detect RAW hazards against in-flight producers.

---
 rtl/ysyx_25060170_gpr_pkg.sv | 22 ++
 rtl/ysyx_25060170_gpr_sb.sv | 38 +++
 rtl/ysyx_25060170_gpr_mp.sv | 80 ++++++++
 tb/tb_ysyx_25060170_gpr_mp.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ysyx_25060170_gpr_pkg.sv
// ysyx_25060170_gpr_pkg: shared defaults and helpers for the multi-port GPR file.
package ysyx_25060170_gpr_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) if ((1 << r) < n) r++;
        return r;
    endfunction

    // Index of the highest set bit, -1 when none; the highest write port wins.
    function automatic int last_hit(input logic [31:0] hit);
        int s;
        s = -1;
        for (int i = 0; i < 32; i++) if (hit[i]) s = i;
        return s;
    endfunction

endpackage

// File: rtl/ysyx_25060170_gpr_sb.sv
// ysyx_25060170_gpr_sb: per-register busy scoreboard (alloc sets, write clears, flush wipes).
module ysyx_25060170_gpr_sb
    import ysyx_25060170_gpr_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              flush,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] busy_q, busy_d, clr, set;

    // A new producer supersedes a completing one, so set is applied after clear.
    always_comb begin
        clr = '0;
        for (int p = 0; p < NWR; p++) if (wr_en[p]) clr[wr_addr[p*AW +: AW]] = 1'b1;
        set = alloc_en ? (NREG'(1) << alloc_addr) : '0;
        busy_d = flush ? '0 : ((busy_q & ~clr) | set);
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/ysyx_25060170_gpr_mp.sv
// ysyx_25060170_gpr_mp: NRD-read / NWR-write register file with optional write bypass
// and an integrated pending-write scoreboard for RAW hazard detection.
module ysyx_25060170_gpr_mp
    import ysyx_25060170_gpr_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    // Ports applied in ascending order so the highest colliding port lands last.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NWR; p++)
            if (wr_en[p] && !(ZERO_REG != 0 && wr_addr[p*AW +: AW] == '0))
                regs_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    ysyx_25060170_gpr_sb #(
        .NREG     (NREG),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .flush      (flush),
        .busy_vec   (busy_vec)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   a;
        logic [31:0]     hit;
        logic [XLEN-1:0] val;
        int              sel;
        assign a = rd_addr[k*AW +: AW];
        always_comb begin
            hit = '0;
            for (int p = 0; p < NWR; p++) hit[p] = wr_en[p] && (wr_addr[p*AW +: AW] == a);
            sel = last_hit(hit);
            val = regs_q[a];
            if (BYPASS != 0 && sel >= 0) val = wr_data[sel*XLEN +: XLEN];
            if (ZERO_REG != 0 && a == '0) val = '0;
        end
        assign rd_data[k*XLEN +: XLEN] = val;
        assign rd_busy[k] = busy_vec[a];
    end

endmodule

// File: tb/tb_ysyx_25060170_gpr_mp.sv
// tb_ysyx_25060170_gpr_mp: directed and random stimulus against an array/bit reference model,
// with a bypassing and a non-bypassing instance driven in parallel.
module tb_ysyx_25060170_gpr_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ra [2];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [1:0]  we;
    logic        alloc_en, flush;
    logic [4:0]  alloc_addr;

    logic [9:0]  rd_addr, wr_addr;
    logic [63:0] wr_data, rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic [31:0] busy_vec, busy_vec_nb;

    int checks = 0;
    int errors = 0;

    bit [31:0] m_reg [32];
    bit        m_busy [32];

    assign rd_addr = {ra[1], ra[0]};
    assign wr_addr = {wa[1], wa[0]};
    assign wr_data = {wd[1], wd[0]};

    always #5 clk = ~clk;

    ysyx_25060170_gpr_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(we), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .flush(flush), .busy_vec(busy_vec)
    );

    ysyx_25060170_gpr_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(we), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .flush(flush), .busy_vec(busy_vec_nb)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] exp_rd(input bit [4:0] a, input bit bypass);
        bit [31:0] v;
        if (a == 0) return 0;
        v = m_reg[a];
        if (bypass) for (int p = 0; p < 2; p++) if (we[p] && wa[p] == a) v = wd[p];
        return v;
    endfunction

    function automatic bit [31:0] exp_busy_vec();
        bit [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 0;
            m_busy[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit written [32];
        for (int i = 0; i < 32; i++) written[i] = 0;
        for (int p = 0; p < 2; p++) if (we[p]) begin
            written[wa[p]] = 1;
            if (wa[p] != 0) m_reg[wa[p]] = wd[p];
        end
        for (int i = 1; i < 32; i++) begin
            if (flush) m_busy[i] = 0;
            else if (alloc_en && alloc_addr == i) m_busy[i] = 1;
            else if (written[i]) m_busy[i] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rd_data%0d a=%0d", k, ra[k]), rd_data[k*32 +: 32], exp_rd(ra[k], 1));
            check($sformatf("rd_data_nb%0d a=%0d", k, ra[k]), rd_data_nb[k*32 +: 32], exp_rd(ra[k], 0));
            check($sformatf("rd_busy%0d a=%0d", k, ra[k]), rd_busy[k], m_busy[ra[k]]);
            check($sformatf("rd_busy_nb%0d", k), rd_busy_nb[k], m_busy[ra[k]]);
        end
        check("busy_vec", busy_vec, exp_busy_vec());
        check("busy_vec_nb", busy_vec_nb, exp_busy_vec());
    endtask

    task automatic step(input bit e0, input bit [4:0] a0, input bit [31:0] d0,
                        input bit e1, input bit [4:0] a1, input bit [31:0] d1,
                        input bit al, input bit [4:0] aa, input bit fl,
                        input bit [4:0] r0, input bit [4:0] r1);
        @(negedge clk);
        we = {e1, e0}; wa[0] = a0; wa[1] = a1; wd[0] = d0; wd[1] = d1;
        alloc_en = al; alloc_addr = aa; flush = fl; ra[0] = r0; ra[1] = r1;
        #1 check_outputs();
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input bit [4:0] r0, input bit [4:0] r1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
    endtask

    initial begin
        we = 0; wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
        alloc_en = 0; alloc_addr = 0; flush = 0; ra[0] = 5; ra[1] = 31;
        model_reset();
        #12 check_outputs();
        @(negedge clk) rst = 1'b1;
        idle(0, 5);
        idle(31, 0);
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 5, 5);
        idle(0, 5);
        check("x5_stored", rd_data[63:32], 32'hDEADBEEF);
        step(1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0, 0, 7, 7);
        check("x7_bypass_collide", rd_data[31:0], 32'h22222222);
        step(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 7, 0);
        idle(0, 7);
        check("x7_collide", rd_data[63:32], 32'h22222222);
        check("x0_zero", rd_data[31:0], 32'h0);
        step(0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 0);
        idle(3, 0);
        check("busy3_a", busy_vec[3], 1'b1);
        idle(3, 0);
        step(1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 3, 0);
        check("busy3_held_in_write", rd_busy[0], 1'b1);
        idle(3, 0);
        check("busy3_cleared", busy_vec[3], 1'b0);
        step(1, 3, 32'h34, 0, 0, 0, 1, 3, 0, 3, 0);
        idle(3, 0);
        check("busy3_alloc_wins", busy_vec[3], 1'b1);
        step(1, 4, 32'h44, 1, 9, 32'h99, 1, 4, 0, 4, 9);
        step(0, 0, 0, 0, 0, 0, 1, 9, 0, 4, 9);
        step(0, 0, 0, 0, 0, 0, 1, 12, 1, 4, 9);
        idle(4, 9);
        check("flush_busy", busy_vec, 32'h0);
        check("flush_x4", rd_data[31:0], 32'h44);
        check("flush_x9", rd_data[63:32], 32'h99);
        step(0, 0, 0, 0, 0, 0, 1, 3, 0, 5, 3);
        @(negedge clk);
        we = 0; alloc_en = 0; flush = 0; ra[0] = 5; ra[1] = 3;
        #1 check("pre_reset_x5", rd_data[31:0], 32'hDEADBEEF);
        check("pre_reset_busy3", busy_vec[3], 1'b1);
        #1 rst = 1'b0;
        #1 check("async_rst_x5", rd_data[31:0], 32'h0);
        check("async_rst_busy", busy_vec, 32'h0);
        model_reset();
        check_outputs();
        @(negedge clk) rst = 1'b1;
        for (int n = 0; n < 400; n++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            step($urandom_range(0, 2) != 0, narrow ? 5'($urandom_range(0, 7)) : 5'($urandom), $urandom,
                 $urandom_range(0, 2) != 0, narrow ? 5'($urandom_range(0, 7)) : 5'($urandom), $urandom,
                 $urandom_range(0, 1) == 1, narrow ? 5'($urandom_range(0, 7)) : 5'($urandom),
                 $urandom_range(0, 19) == 0,
                 narrow ? 5'($urandom_range(0, 7)) : 5'($urandom),
                 narrow ? 5'($urandom_range(0, 7)) : 5'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
